image_size_up_2x: RTL and testbench

//  2x nearest-neighbour upscaler: the inverse of the 2:1 decimating downscaler in the video path.

---
 rtl/image_size_up_2x.sv | 161 ++++++++++++++++
 tb/tb_image_size_up_2x.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_size_up_2x.sv
// 2x nearest-neighbour upscaler: each pixel emitted twice, each line
// replayed once from a single-line buffer.
module image_size_up_2x #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           width_i,
    input  logic [15:0]           height_i,
    input  logic [DATA_WIDTH-1:0] tdata_i,
    input  logic                  tvalid_i,
    output logic                  tready_o,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tvalid_o,
    output logic                  tlast_o,
    output logic                  tuser_o
);

    typedef enum logic {
        LINE_IN,
        LINE_REP
    } state_t;

    state_t state_q, state_d;
    logic phase_q, phase_d;
    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic [15:0] w_m1_q, w_m1_d;
    logic [15:0] h_m1_q, h_m1_d;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic last_q, last_d;
    logic rd_v_q, rd_v_d;
    logic [DATA_WIDTH-1:0] tdata_d;
    logic tvalid_d, tlast_d, tuser_d;
    logic wr_en, rd_en, first, xfer;
    logic [15:0] w_cur;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_q;

    assign tready_o = (state_q == LINE_IN) && !phase_q;
    assign xfer     = tready_o && tvalid_i;
    assign first    = (row_q == 16'd0) && (col_q == 16'd0);
    // the first pixel of a frame must already see the new width
    assign w_cur    = first ? (width_i - 16'd1) : w_m1_q;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        col_d    = col_q;
        row_d    = row_q;
        w_m1_d   = w_m1_q;
        h_m1_d   = h_m1_q;
        pix_d    = pix_q;
        last_d   = last_q;
        rd_v_d   = rd_v_q;
        tdata_d  = tdata_o;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        unique case (state_q)
            LINE_IN: begin
                if (!phase_q) begin
                    if (xfer) begin
                        wr_en    = 1'b1;
                        pix_d    = tdata_i;
                        tdata_d  = tdata_i;
                        tvalid_d = 1'b1;
                        tuser_d  = first;
                        last_d   = (col_q == w_cur);
                        phase_d  = 1'b1;
                        col_d    = col_q + 16'd1;
                        if (first) begin
                            w_m1_d = width_i - 16'd1;
                            h_m1_d = height_i - 16'd1;
                        end
                    end
                end else begin
                    tdata_d  = pix_q;
                    tvalid_d = 1'b1;
                    tlast_d  = last_q;
                    phase_d  = 1'b0;
                    if (last_q) begin
                        state_d = LINE_REP;
                        col_d   = 16'd0;
                        rd_v_d  = 1'b0;
                    end
                end
            end
            LINE_REP: begin
                // phase 0: copy 2 of previous read plus next read; phase 1: copy 1
                if (!phase_q) begin
                    if (rd_v_q) begin
                        tdata_d  = rd_q;
                        tvalid_d = 1'b1;
                        tlast_d  = last_q;
                    end
                    if (rd_v_q && last_q) begin
                        state_d = LINE_IN;
                        col_d   = 16'd0;
                        rd_v_d  = 1'b0;
                        last_d  = 1'b0;
                        row_d   = (row_q == h_m1_q) ? 16'd0 : row_q + 16'd1;
                    end else begin
                        rd_en   = 1'b1;
                        last_d  = (col_q == w_m1_q);
                        phase_d = 1'b1;
                    end
                end else begin
                    tdata_d  = rd_q;
                    tvalid_d = 1'b1;
                    col_d    = col_q + 16'd1;
                    rd_v_d   = 1'b1;
                    phase_d  = 1'b0;
                end
            end
            default: state_d = LINE_IN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= LINE_IN;
            phase_q  <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            w_m1_q   <= '0;
            h_m1_q   <= '0;
            pix_q    <= '0;
            last_q   <= 1'b0;
            rd_v_q   <= 1'b0;
            tdata_o  <= '0;
            tvalid_o <= 1'b0;
            tlast_o  <= 1'b0;
            tuser_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            col_q    <= col_d;
            row_q    <= row_d;
            w_m1_q   <= w_m1_d;
            h_m1_q   <= h_m1_d;
            pix_q    <= pix_d;
            last_q   <= last_d;
            rd_v_q   <= rd_v_d;
            tdata_o  <= tdata_d;
            tvalid_o <= tvalid_d;
            tlast_o  <= tlast_d;
            tuser_o  <= tuser_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[col_q[ADDR_WIDTH-1:0]] <= tdata_i;
        if (rd_en) rd_q <= mem[col_q[ADDR_WIDTH-1:0]];
    end

endmodule

// File: tb/tb_image_size_up_2x.sv
// Scoreboard bench for the 2x upscaler: expected pixels queued at
// stimulus time, popped as the DUT emits them.
module tb_image_size_up_2x;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] width_i, height_i;
    logic [15:0] tdata_i;
    logic        tvalid_i;
    logic        tready_o;
    logic [15:0] tdata_o;
    logic        tvalid_o, tlast_o, tuser_o;

    image_size_up_2x #(.DATA_WIDTH(16), .ADDR_WIDTH(11)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .width_i(width_i), .height_i(height_i),
        .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tready_o(tready_o),
        .tdata_o(tdata_o), .tvalid_o(tvalid_o),
        .tlast_o(tlast_o), .tuser_o(tuser_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic        u;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int run_len = 0;
    int run_at_last = 0;
    logic prev_xfer = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_i !== 1'b1) begin
            if (prev_xfer) begin
                checks++;
                if (tready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL tready_after_xfer got %b want 0", tready_o);
                end
            end
            if (tvalid_o === 1'b1) begin
                run_len++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got %h want none", tdata_o);
                end else begin
                    e = q.pop_front();
                    if ({tdata_o, tlast_o, tuser_o} !== {e.d, e.l, e.u}) begin
                        errors++;
                        $display("FAIL pixel got %h l%b u%b want %h l%b u%b",
                                 tdata_o, tlast_o, tuser_o, e.d, e.l, e.u);
                    end
                end
                if (tlast_o === 1'b1) run_at_last = run_len;
            end else begin
                run_len = 0;
            end
        end else begin
            run_len = 0;
        end
        prev_xfer = tvalid_i & tready_o & (rst_i !== 1'b1);
    end

    task automatic send_pixel(input logic [15:0] d, input bit f, input bit l);
        int n = 0;
        bit ok;
        tdata_i  = d;
        tvalid_i = 1'b1;
        do begin
            ok = tready_o;
            if (ok) begin
                q.push_back('{d: d, l: 1'b0, u: f});
                q.push_back('{d: d, l: l, u: 1'b0});
            end
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 20000);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout got 0 want 1");
        end
    endtask

    task automatic send_frame(input int w, input int h,
                              input logic [15:0] base, input int gap);
        logic [15:0] d;
        width_i  = 16'(w);
        height_i = 16'(h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                d = base + 16'(r * w + c);
                send_pixel(d, (r == 0 && c == 0), (c == w - 1));
                if (c == w - 1) begin
                    for (int k = 0; k < w; k++) begin
                        d = base + 16'(r * w + k);
                        q.push_back('{d: d, l: 1'b0, u: 1'b0});
                        q.push_back('{d: d, l: (k == w - 1), u: 1'b0});
                    end
                end
                if (gap > 0) begin
                    tvalid_i = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
            end
        end
        tvalid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d left want 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        tvalid_i = 1'b0;
        tdata_i  = '0;
        width_i  = 16'd4;
        height_i = 16'd2;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tdata_o, tvalid_o, tlast_o, tuser_o} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outs got %h %b%b%b want 0",
                     tdata_o, tvalid_o, tlast_o, tuser_o);
        end
        checks++;
        if (tready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", tready_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        send_frame(4, 2, 16'd0, 0);
        drain();
    endtask

    task automatic test_gaps();
        send_frame(4, 2, 16'd0, 2);
        drain();
    endtask

    task automatic test_tiny();
        send_frame(1, 1, 16'hABCD, 0);
        drain();
    endtask

    task automatic test_max_width();
        run_at_last = 0;
        send_frame(2048, 1, 16'd0, 0);
        drain();
        checks++;
        if (run_at_last < 4096) begin
            errors++;
            $display("FAIL replay_run got %0d want >=4096", run_at_last);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        width_i  = 16'd4;
        height_i = 16'd2;
        for (int c = 0; c < 4; c++)
            send_pixel(16'(c), (c == 0), (c == 3));
        tvalid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            q.push_back('{d: 16'(k), l: 1'b0, u: 1'b0});
            q.push_back('{d: 16'(k), l: (k == 3), u: 1'b0});
        end
        while (q.size() > 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        q.delete();
        checks++;
        if (tvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid got %b want 0", tvalid_o);
        end
        checks++;
        if (tready_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready got %b want 1", tready_o);
        end
        send_frame(4, 2, 16'd0, 0);
        drain();
    endtask

    task automatic test_back_to_back();
        send_frame(4, 2, 16'd100, 0);
        send_frame(2, 2, 16'd200, 0);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_tiny();
        test_max_width();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
